// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared constants for the fetch queue: RV32 control-flow opcodes used by
//   the optional predecode and the canonical NOP (addi x0,x0,0) driven while
//   the queue is empty.
//   Contents:
//     OPC_BRANCH, OPC_JAL, OPC_JALR : 7-bit major opcodes (B-type, J-type, jalr)
//     FQ_NOP_INST                   : 32'h00000013
//     is_ctrl_opcode()              : 1 when an opcode redirects control flow
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  OPC_JALR    = 7'b1100111;

    localparam logic [31:0] FQ_NOP_INST = 32'h00000013;

    function automatic logic is_ctrl_opcode(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular instruction queue between fetch and decode. Valid/ready on both
//   sides decouples fetch from decode stalls; flush drops every queued entry
//   on a redirect. The head entry is presented combinationally; an entry
//   pushed into an empty queue is visible on the following cycle.
//
//   Optional feature (macro FETCHQ_PREDECODE_EN): each pushed instruction is
//   tagged with a control-flow bit (branch/jal/jalr) driven on out_is_ctrl.
//   Without the macro no tag is stored and out_is_ctrl is tied low.
//
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     in_valid/in_ready   fetch handshake; in_pc/in_inst carried with it
//     out_valid/out_ready decode handshake; out_pc/out_inst/out_is_ctrl head
//     flush               synchronous discard of all entries (highest priority)
//     count               current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(FQ_NOP_INST)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_inst,
    output logic                      out_is_ctrl,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);

    // Flush suppresses both handshakes, so the instruction offered alongside
    // it is dropped and nothing is popped.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Storage is data only and deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

`ifdef FETCHQ_PREDECODE_EN
    logic ctrl_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr] <= is_ctrl_opcode(in_inst[6:0]);
        end
    end

    assign out_is_ctrl = out_valid ? ctrl_mem[rd_ptr] : 1'b0;
`else
    assign out_is_ctrl = 1'b0;
`endif

    assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
    assign out_inst = out_valid ? inst_mem[rd_ptr] : NOP_INST;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small circular instruction queue between the fetch stage (PC plus instruction memory) and the decode stage.
- Decode feeds the queue head instruction into the immediate generator and the control decoder.
- Decouples fetch from decode stalls using valid/ready handshakes on both sides.
- Supports a synchronous flush for branch/jump redirects.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of PC and instruction.
- NOP_INST, 32'h00000013, value driven on out_inst while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction this cycle.
- in_pc  in  XLEN  PC of the fetched instruction.
- in_inst  in  XLEN  fetched instruction word.
- out_valid  out  1  head entry is valid for decode.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  XLEN  PC of the head entry.
- out_inst  out  XLEN  head instruction word.
- out_is_ctrl  out  1  head is a branch, jal or jalr (optional feature only).
- flush  in  1  discard all queued entries (redirect).
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: storage array [DEPTH] of {pc, inst, is_ctrl}, plus wr_ptr and rd_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and count.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Outputs: out_valid=0, in_ready=1, out_pc=0, out_inst=NOP_INST, out_is_ctrl=0. The storage array is not reset.
- in_ready = (count != DEPTH). It is registered-state derived only; there is no combinational path from out_ready.
- out_valid = (count != 0).
- out_pc, out_inst, out_is_ctrl come combinationally from entry[rd_ptr] when out_valid=1. When out_valid=0 they are 0, NOP_INST and 0.
- push = in_valid && in_ready. Entry[wr_ptr] <= {in_pc, in_inst, ctrl}; wr_ptr++.
- pop = out_valid && out_ready. rd_ptr++.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Latency: a push into an empty queue appears on out_* the next cycle. There is no same-cycle bypass.
- Full (count=DEPTH): in_ready=0, so a push is impossible. A pop in that cycle makes in_ready=1 next cycle.
- Empty: a pop is impossible. A simultaneous push just fills the queue.
- Wrap-around: the pointers roll from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
- flush=1 (synchronous, highest priority):
  - next cycle wr_ptr=rd_ptr=0 and count=0;
  - any push or pop in the same cycle is ignored, so the instruction presented with flush is dropped;
  - out_valid=0 the following cycle;
  - in_ready stays whatever it was this cycle; fetch sees the drop only via flush.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- The block does not modify or inspect instruction bits, except in the optional predecode.

Optional Feature:
- Macro: FETCHQ_PREDECODE_EN.
- Defined: on push, ctrl = (in_inst[6:0] == `Btype || `Jtype || `ItypeJ) using the opcode constants from define.vh. ctrl is stored per entry and driven on out_is_ctrl with the head.
- Undefined: no is_ctrl storage; out_is_ctrl is tied to 0.

Decomposition:
- Opcode constants (`Btype, `Jtype, `ItypeJ) stay in the shared define.vh header.
- Add `NOP_INST 32'h00000013 to define.vh and use it as the NOP_INST default.
- Single module; no sub-module. Storage is an inferred register array.

Test Plan:
- Reset: assert rst mid-cycle with count=3 -> immediately count=0, out_valid=0, out_inst=32'h00000013, in_ready=1.
- Fill: push pc 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is not accepted; out_pc=0x0.
- Simultaneous push and pop while count=2 -> count stays 2; the popped head advances from 0x0 to 0x4.
- Wrap-around: stream 10 instructions with out_ready toggling 1/0 -> decode sees pc 0x0..0x24 in order, no loss, no duplicates.
- Flush with in_valid=1 (pc 0x40) and count=3 -> next cycle count=0 and out_valid=0; pc 0x40 never appears at the output.
- Predecode (FETCHQ_PREDECODE_EN):
  - push 32'h00000063 (beq) -> out_is_ctrl=1;
  - push 32'h00000013 -> out_is_ctrl=0;
  - with the macro undefined, out_is_ctrl is always 0.
